// File: rtl/csr_regfile_ext.sv
// csr_regfile_ext: machine-mode CSR file with software CSR ops, 64-bit counters, trap entry and mret
module csr_regfile_ext #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] HART_ID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re_i,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] data_o,
  input  logic            we_i,
  input  logic [1:0]      op_i,
  input  logic [11:0]     waddr_i,
  input  logic [XLEN-1:0] data_i,
  output logic            illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic [2:0]      irq_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic            global_int_en_o,
  output logic            irq_pending_o
);
  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]      ie_q, ie_d, ip_q, ip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] mstatus_v, ie_v, ip_v, cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic [XLEN:0]   rd, wr;
  logic [XLEN-1:0] old, msk, opv, wval;
  logic [63:0]     wval64;
  logic            wr_ok;
  assign mstatus_v = XLEN'({mst_mpie_q, 3'b000, mst_mie_q, 3'b000}) | XLEN'(13'h1800);
  assign ie_v      = XLEN'({ie_q[2], 3'b000, ie_q[1], 3'b000, ie_q[0], 3'b000});
  assign ip_v      = XLEN'({ip_q[2], 3'b000, ip_q[1], 3'b000, ip_q[0], 3'b000});
  assign cyc_lo    = HAS_COUNTERS ? XLEN'(mcycle_q) : '0;
  assign cyc_hi    = HAS_COUNTERS ? XLEN'(mcycle_q >> 32) : '0;
  assign ins_lo    = HAS_COUNTERS ? XLEN'(minstret_q) : '0;
  assign ins_hi    = HAS_COUNTERS ? XLEN'(minstret_q >> 32) : '0;
  // {implemented, read view} of a CSR address
  function automatic logic [XLEN:0] view(input logic [11:0] a);
    case (a)
      12'h300:         view = {1'b1, mstatus_v};
      12'h304:         view = {1'b1, ie_v};
      12'h305:         view = {1'b1, mtvec_q};
      12'h340:         view = {1'b1, mscratch_q};
      12'h341:         view = {1'b1, mepc_q};
      12'h342:         view = {1'b1, mcause_q};
      12'h344:         view = {1'b1, ip_v};
      12'hB00, 12'hC00: view = {1'b1, cyc_lo};
      12'hB02, 12'hC02: view = {1'b1, ins_lo};
      12'hB80, 12'hC80: view = {XLEN == 32, cyc_hi};
      12'hB82, 12'hC82: view = {XLEN == 32, ins_hi};
      12'hF14:         view = {1'b1, HART_ID};
      default:         view = '0;
    endcase
  endfunction
  function automatic logic [XLEN-1:0] wmask(input logic [11:0] a);
    case (a)
      12'h300:                            wmask = XLEN'(12'h088);
      12'h304:                            wmask = XLEN'(12'h888);
      12'h305, 12'h341:                   wmask = ~XLEN'(3);
      12'h340, 12'h342:                   wmask = '1;
      12'hB00, 12'hB02, 12'hB80, 12'hB82: wmask = HAS_COUNTERS ? '1 : '0;
      default:                            wmask = '0;
    endcase
  endfunction
  assign rd        = view(raddr_i);
  assign wr        = view(waddr_i);
  assign illegal_o = (re_i && !rd[XLEN]) ||
                     (we_i && (!wr[XLEN] || waddr_i[11:10] == 2'b11 || op_i == 2'b11));
  assign wr_ok     = we_i && !illegal_o;
  assign old       = wr[XLEN-1:0];
  assign msk       = wmask(waddr_i);
  assign opv       = op_i == 2'b00 ? data_i : op_i == 2'b01 ? (old | data_i) : (old & ~data_i);
  // Bits outside the WARL mask keep their read view (e.g. MPP, mip)
  assign wval      = (opv & msk) | (old & ~msk);
  assign wval64    = 64'(wval);
  assign data_o    = !re_i ? '0 : (wr_ok && raddr_i == waddr_i) ? wval : rd[XLEN-1:0];
  always_comb begin
    mtvec_d    = wr_ok && waddr_i == 12'h305 ? wval : mtvec_q;
    mscratch_d = wr_ok && waddr_i == 12'h340 ? wval : mscratch_q;
    mepc_d     = trap_i ? (trap_pc_i & ~XLEN'(3)) : wr_ok && waddr_i == 12'h341 ? wval : mepc_q;
    mcause_d   = trap_i ? trap_cause_i : wr_ok && waddr_i == 12'h342 ? wval : mcause_q;
    ie_d       = wr_ok && waddr_i == 12'h304 ? {wval[11], wval[7], wval[3]} : ie_q;
    ip_d       = irq_i;
    mst_mie_d  = trap_i ? 1'b0 : mret_i ? mst_mpie_q : wr_ok && waddr_i == 12'h300 ? wval[3] : mst_mie_q;
    mst_mpie_d = trap_i ? mst_mie_q : mret_i ? 1'b1 : wr_ok && waddr_i == 12'h300 ? wval[7] : mst_mpie_q;
    mcycle_d   = !HAS_COUNTERS ? '0 :
                 wr_ok && waddr_i == 12'hB00 ? (XLEN == 32 ? {mcycle_q[63:32], wval64[31:0]} : wval64) :
                 wr_ok && waddr_i == 12'hB80 ? {wval64[31:0], mcycle_q[31:0]} :
                 mcycle_q + 64'd1;
    minstret_d = !HAS_COUNTERS ? '0 :
                 wr_ok && waddr_i == 12'hB02 ? (XLEN == 32 ? {minstret_q[63:32], wval64[31:0]} : wval64) :
                 wr_ok && waddr_i == 12'hB82 ? {wval64[31:0], minstret_q[31:0]} :
                 minstret_q + 64'(instret_i);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtvec_q    <= MTVEC_RESET & ~XLEN'(3);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      ie_q       <= '0;
      ip_q       <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      ie_q       <= ie_d;
      ip_q       <= ip_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_v;
  assign global_int_en_o = mst_mie_q;
  assign irq_pending_o   = mst_mie_q && |(ie_q & ip_q);
endmodule
